// File: rtl/elevator_call_scheduler_if.sv
// Call-button, car-feedback and command bundle between the buttons/car (master)
// and the scheduler (slave).
interface elevator_call_scheduler_if;
  logic       ra;
  logic       rb;
  logic       rc;
  logic       rd;
  logic [1:0] car_floor;
  logic       car_arrived;
  logic       move_up;
  logic       move_down;
  logic       door_open;
  logic       dir;
  logic [3:0] pending;

  modport master (
    output ra, rb, rc, rd, car_floor, car_arrived,
    input  move_up, move_down, door_open, dir, pending
  );

  modport slave (
    input  ra, rb, rc, rd, car_floor, car_arrived,
    output move_up, move_down, door_open, dir, pending
  );
endinterface

// File: rtl/elevator_call_scheduler.sv
// 4-floor SCAN call scheduler: latches hall calls, commands car motion and times door dwell.
// Call pulse at edge k is visible in pending after k; motion/door output rises after k+1.
module elevator_call_scheduler #(
  parameter int DOOR_CYCLES = 4,
  parameter int CNT_W       = 3
) (
  input logic                    clk,
  input logic                    rst,
  elevator_call_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    DOOR = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             dir_nxt;
  logic [3:0]       calls;
  logic [3:0]       here;
  logic [3:0]       clr;
  logic             hit;
  logic             call_here;
  logic             any_above;
  logic             any_below;

  always_comb begin
    calls     = {bus.rd, bus.rc, bus.rb, bus.ra};
    here      = 4'b0001 << bus.car_floor;
    hit       = |(bus.pending & here);
    call_here = |(calls & here);
    any_above = |(bus.pending & (4'b1110 << bus.car_floor));
    any_below = |(bus.pending & (here - 4'd1));
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dir_nxt   = bus.dir;
    clr       = 4'b0000;
    case (state)
      IDLE: begin
        if (hit) begin
          state_nxt = DOOR;
          cnt_nxt   = CNT_LOAD;
          clr       = here;
        end else if (any_above && (bus.dir || !any_below)) begin
          state_nxt = UP;
          dir_nxt   = 1'b1;
        end else if (any_below) begin
          state_nxt = DOWN;
          dir_nxt   = 1'b0;
        end
      end
      UP: begin
        if (bus.car_arrived) begin
          if (hit) begin
            state_nxt = DOOR;
            cnt_nxt   = CNT_LOAD;
            clr       = here;
          end else if (bus.car_floor == 2'd3) begin
            state_nxt = IDLE;
          end
        end
      end
      DOWN: begin
        if (bus.car_arrived) begin
          if (hit) begin
            state_nxt = DOOR;
            cnt_nxt   = CNT_LOAD;
            clr       = here;
          end else if (bus.car_floor == 2'd0) begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        // Calls for the floor whose door is open are absorbed and extend the dwell.
        clr = here;
        if (call_here) begin
          cnt_nxt = CNT_LOAD;
        end else if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.dir       <= 1'b1;
      bus.pending   <= 4'b0000;
      bus.move_up   <= 1'b0;
      bus.move_down <= 1'b0;
      bus.door_open <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      bus.dir       <= dir_nxt;
      bus.pending   <= (bus.pending | calls) & ~clr;
      bus.move_up   <= (state_nxt == UP);
      bus.move_down <= (state_nxt == DOWN);
      bus.door_open <= (state_nxt == DOOR);
    end
  end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Bench for elevator_call_scheduler: directed scenarios plus random call bursts against
// a behavioural model, with a simple car that arrives 3 cycles into each floor move.
module tb_elevator_call_scheduler;
  localparam int DOOR_CYCLES = 4;
  localparam int AGE_LIMIT   = 40;

  typedef struct packed {
    int         motion;     // +1 travelling up, -1 travelling down, 0 stopped
    int         door_left;  // door-open cycles still to go, 0 = closed
    logic [3:0] pend;
    logic       pref_up;
  } model_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] calls_q = 4'b0000;
  logic [1:0] car_floor_q = 2'd0;
  logic       car_arr_q = 1'b0;
  int         mv_cnt = 0;
  int         age [4];
  logic [3:0] prev_pend = 4'b0000;
  model_t     m;
  int         n_cmp = 0;
  int         n_bad = 0;

  elevator_call_scheduler_if bus ();
  assign bus.ra          = calls_q[0];
  assign bus.rb          = calls_q[1];
  assign bus.rc          = calls_q[2];
  assign bus.rd          = calls_q[3];
  assign bus.car_floor   = car_floor_q;
  assign bus.car_arrived = car_arr_q;

  elevator_call_scheduler #(.DOOR_CYCLES(DOOR_CYCLES), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of the car's world as described by the scheduling rules.
  function automatic model_t model_step(model_t cur, logic [3:0] c, int cf, logic arr);
    model_t nx = cur;
    int served = -1;
    bit above = 1'b0;
    bit below = 1'b0;
    if (cur.door_left > 0) begin
      served = cf;
      nx.door_left = c[cf] ? DOOR_CYCLES : cur.door_left - 1;
    end else if (cur.motion != 0) begin
      if (arr) begin
        if (cur.pend[cf]) begin
          served = cf;
          nx.motion = 0;
          nx.door_left = DOOR_CYCLES;
        end else if ((cur.motion > 0 && cf == 3) || (cur.motion < 0 && cf == 0)) begin
          nx.motion = 0;
        end
      end
    end else if (cur.pend[cf]) begin
      served = cf;
      nx.door_left = DOOR_CYCLES;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cur.pend[i] && i > cf) above = 1'b1;
        if (cur.pend[i] && i < cf) below = 1'b1;
      end
      if (above && (cur.pref_up || !below)) begin
        nx.motion = 1;
        nx.pref_up = 1'b1;
      end else if (below) begin
        nx.motion = -1;
        nx.pref_up = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++)
      nx.pend[i] = (cur.pend[i] | c[i]) && (i != served);
    return nx;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '{motion: 0, door_left: 0, pend: 4'b0000, pref_up: 1'b1};
    else     m <= model_step(m, calls_q, int'(car_floor_q), car_arr_q);
  end

  // Compare, invariants, call ageing, then advance the car.
  always @(negedge clk) begin
    if (rst) begin
      mv_cnt    <= 0;
      car_arr_q <= 1'b0;
      prev_pend <= 4'b0000;
      for (int i = 0; i < 4; i++) age[i] <= 0;
    end else begin
      check("move_up",   int'(bus.move_up),   int'(m.motion > 0));
      check("move_down", int'(bus.move_down), int'(m.motion < 0));
      check("door_open", int'(bus.door_open), int'(m.door_left > 0));
      check("dir",       int'(bus.dir),       int'(m.pref_up));
      check("pending",   int'(bus.pending),   int'(m.pend));
      check("invariant", int'((bus.move_up && bus.move_down) ||
                              (bus.door_open && (bus.move_up || bus.move_down)) ||
                              (!car_arr_q && bus.move_up && car_floor_q == 2'd3) ||
                              (!car_arr_q && bus.move_down && car_floor_q == 2'd0)), 0);
      for (int i = 0; i < 4; i++) begin
        if (bus.pending[i]) begin
          age[i] <= age[i] + 1;
          if (age[i] == AGE_LIMIT) check("pending_age", age[i] + 1, AGE_LIMIT);
        end else begin
          age[i] <= 0;
          if (prev_pend[i]) check("pending_cleared_in_time", int'(age[i] <= AGE_LIMIT), 1);
        end
      end
      prev_pend <= bus.pending;
      if (car_arr_q) begin
        car_arr_q <= 1'b0;
        mv_cnt    <= 0;
      end else if (bus.move_up || bus.move_down) begin
        if (mv_cnt == 2) begin
          car_arr_q <= 1'b1;
          mv_cnt    <= 0;
          if (bus.move_up && car_floor_q != 2'd3)   car_floor_q <= car_floor_q + 2'd1;
          if (bus.move_down && car_floor_q != 2'd0) car_floor_q <= car_floor_q - 2'd1;
        end else begin
          mv_cnt <= mv_cnt + 1;
        end
      end else begin
        mv_cnt <= 0;
      end
    end
  end

  task automatic pulse(input logic [3:0] bits);
    @(negedge clk);
    calls_q = bits;
    @(negedge clk);
    calls_q = 4'b0000;
  endtask

  task automatic wait_door(output int lat, output int fl, output int len);
    lat = 0;
    len = 0;
    while (!bus.door_open && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.door_open) check("door_timeout", 0, 1);
    fl = int'(car_floor_q);
    while (bus.door_open && len < 20) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic wait_model_idle();
    int n = 0;
    while (!(m.motion == 0 && m.door_left == 0 && m.pend == 4'b0000) && n < 120) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", int'(n < 120), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1);
  end

  initial begin
    int lat, fl, len, n;
    #12;
    check("rst_pending", int'(bus.pending), 0);
    check("rst_dir", int'(bus.dir), 1);
    check("rst_outputs", int'({bus.move_up, bus.move_down, bus.door_open}), 0);
    @(negedge clk);
    rst = 1'b0;

    // Call at the car's own floor: door only, no motion.
    pulse(4'b0001);
    wait_door(lat, fl, len);
    check("t1_door_latency", lat, 1);
    check("t1_door_floor", fl, 0);
    check("t1_door_len", len, 4);
    check("t1_pending_end", int'(bus.pending), 0);

    // Single call two floors up.
    pulse(4'b0100);
    check("t2_pending", int'(bus.pending), 4'b0100);
    @(negedge clk);
    check("t2_move_up", int'(bus.move_up), 1);
    check("t2_dir", int'(bus.dir), 1);
    n = 0;
    while (!(car_arr_q && car_floor_q == 2'd1) && n < 40) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check("t2_pass_floor1_move_up", int'(bus.move_up), 1);
    wait_door(lat, fl, len);
    check("t2_door_floor", fl, 2);
    check("t2_door_len", len, 4);
    check("t2_pending_end", int'(bus.pending), 0);

    // Simultaneous calls behind and ahead: SCAN serves 3, then 1, then 0.
    pulse(4'b1011);
    check("t3_pending", int'(bus.pending), 4'b1011);
    wait_door(lat, fl, len);
    check("t3_first_floor", fl, 3);
    wait_door(lat, fl, len);
    check("t3_second_floor", fl, 1);
    check("t3_dir_after_top", int'(bus.dir), 0);
    wait_door(lat, fl, len);
    check("t3_third_floor", fl, 0);

    // Same-floor call during dwell reloads the door timer.
    pulse(4'b0010);
    n = 0;
    while (!bus.door_open && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t4_door_floor", int'(car_floor_q), 1);
    calls_q = 4'b0010;
    len = 1;
    @(negedge clk);
    calls_q = 4'b0000;
    while (bus.door_open && len < 20) begin
      len++;
      @(negedge clk);
    end
    check("t4_door_len_reload", len, 5);
    check("t4_pending_end", int'(bus.pending), 0);

    // Reset in the middle of a downward move.
    pulse(4'b1000);
    wait_door(lat, fl, len);
    check("t5_top_floor", fl, 3);
    pulse(4'b0011);
    check("t5_pending", int'(bus.pending), 4'b0011);
    @(negedge clk);
    check("t5_move_down", int'(bus.move_down), 1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_move_down", int'(bus.move_down), 0);
    check("t5_rst_pending", int'(bus.pending), 0);
    check("t5_rst_dir", int'(bus.dir), 1);
    @(negedge clk);
    rst = 1'b0;

    // Random call bursts against the model.
    for (int p = 0; p < 50; p++) begin
      pulse(4'($urandom_range(1, 15)));
      wait_model_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
